// File: rtl/output_port_allocator_if.sv
// Request/grant bundle between the input ports and one output port's allocator.
interface output_port_allocator_if #(
  parameter int N_PORTS = 5
);
  logic [N_PORTS-1:0] req;
  logic [N_PORTS-1:0] tail_sent;
  logic               out_ready;
  logic [N_PORTS-1:0] grant;
  logic               busy;
  logic [2:0]         rr_ptr;
  logic               err_drop;
  logic               err_timeout;

  modport master (
    output req, tail_sent, out_ready,
    input  grant, busy, rr_ptr, err_drop, err_timeout
  );

  modport slave (
    input  req, tail_sent, out_ready,
    output grant, busy, rr_ptr, err_drop, err_timeout
  );
endinterface

// File: rtl/output_port_allocator.sv
// Round-robin wormhole allocator for one mesh-router output port: locks the winner
// from head to tail, re-arbitrates on the tail edge, and watchdogs stuck packets.
module output_port_allocator #(
  parameter int N_PORTS  = 5,
  parameter int HOLD_W   = 8,
  parameter int MAX_HOLD = 200
) (
  input  logic clk,
  input  logic rst,
  output_port_allocator_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]         state;
  logic [N_PORTS-1:0] grant_q;
  logic [2:0]         rr_q;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               err_drop_q, err_timeout_q;

  logic [N_PORTS-1:0] arb_req;
  logic               arb_ok;
  logic [2:0]         arb_idx;
  logic [2:0]         arb_next_ptr;
  logic [N_PORTS-1:0] arb_onehot;
  logic               tail_g, req_g, wd_hit;

  // First set bit scanning upward from ptr with wrap; reverse loop so the
  // lowest offset is assigned last and wins.
  function automatic logic [3:0] rr_pick(input logic [N_PORTS-1:0] r, input logic [2:0] p);
    logic [3:0] res;
    int         i;
    res = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      i = (int'(p) + k) % N_PORTS;
      if (r[i]) res = {1'b1, 3'(i)};
    end
    return res;
  endfunction

  // Masking the held port makes the just-released requester ineligible on the
  // re-arbitration edge; in IDLE grant_q is zero so the mask is a no-op.
  always_comb begin
    arb_req      = bus.req & ~grant_q;
    {arb_ok, arb_idx} = rr_pick(arb_req, rr_q);
    arb_next_ptr = (int'(arb_idx) == N_PORTS - 1) ? 3'd0 : arb_idx + 3'd1;
    arb_onehot   = N_PORTS'(1) << arb_idx;
    tail_g       = |(bus.tail_sent & grant_q);
    req_g        = |(bus.req & grant_q);
    wd_hit       = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      grant_q       <= '0;
      rr_q          <= '0;
      hold_cnt      <= '0;
      err_drop_q    <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      err_drop_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.out_ready && arb_ok) begin
            grant_q  <= arb_onehot;
            rr_q     <= arb_next_ptr;
            hold_cnt <= '0;
            state    <= HOLD;
          end
        end
        default: begin
          if (tail_g) begin
            hold_cnt <= '0;
            if (bus.out_ready && arb_ok) begin
              grant_q <= arb_onehot;
              rr_q    <= arb_next_ptr;
            end else begin
              grant_q <= '0;
              state   <= IDLE;
            end
          end else if (!req_g) begin
            err_drop_q <= 1'b1;
            grant_q    <= '0;
            hold_cnt   <= '0;
            state      <= IDLE;
          end else if (wd_hit) begin
            err_timeout_q <= 1'b1;
            grant_q       <= '0;
            hold_cnt      <= '0;
            state         <= IDLE;
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.busy        = (state == HOLD);
  assign bus.rr_ptr      = rr_q;
  assign bus.err_drop    = err_drop_q;
  assign bus.err_timeout = err_timeout_q;
endmodule

// File: tb/tb_output_port_allocator.sv
// Directed bench for output_port_allocator with the watchdog shortened to 4 cycles.
module tb_output_port_allocator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  output_port_allocator_if #(.N_PORTS(5)) bus ();

  output_port_allocator #(.N_PORTS(5), .HOLD_W(8), .MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1 time unit later, and check the structural invariants.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("onehot0", 8'($onehot0(bus.grant)), 8'd1);
    chk("busy_eq_grant", 8'(bus.busy), 8'(bus.grant != 5'b0));
  endtask

  task automatic chk_state(input string tag, input logic [4:0] g, input logic b, input logic [2:0] p);
    chk({tag, ".grant"}, 8'(bus.grant), 8'(g));
    chk({tag, ".busy"}, 8'(bus.busy), 8'(b));
    chk({tag, ".rr"}, 8'(bus.rr_ptr), 8'(p));
  endtask

  initial begin
    bus.req = '0; bus.tail_sent = '0; bus.out_ready = 1'b0;
    tick(); tick();
    chk_state("reset", 5'b00000, 1'b0, 3'd0);
    chk("reset.err_drop", 8'(bus.err_drop), 8'd0);
    chk("reset.err_timeout", 8'(bus.err_timeout), 8'd0);
    rst = 1'b0;

    // Single request; tail arrives together with req falling (normal release).
    bus.req = 5'b00100; bus.out_ready = 1'b1;
    tick(); chk_state("single", 5'b00100, 1'b1, 3'd3);
    bus.tail_sent = 5'b00100; bus.req = 5'b00000;
    tick(); chk_state("single_rel", 5'b00000, 1'b0, 3'd3);
    chk("single_rel.err_drop", 8'(bus.err_drop), 8'd0);
    bus.tail_sent = '0;

    // Round-robin from ptr 3, then bubble-free hand-offs.
    bus.req = 5'b10011;
    tick(); chk_state("rr_first", 5'b10000, 1'b1, 3'd0);
    bus.tail_sent = 5'b10000; bus.req = 5'b00011;
    tick(); chk_state("rr_handoff", 5'b00001, 1'b1, 3'd1);
    bus.tail_sent = 5'b00001; bus.req = 5'b00010;
    tick(); chk_state("rr_handoff2", 5'b00010, 1'b1, 3'd2);
    bus.tail_sent = 5'b00010; bus.req = 5'b00000;
    tick(); chk_state("rr_done", 5'b00000, 1'b0, 3'd2);
    bus.tail_sent = '0;

    // Same port back-to-back: exactly one idle cycle between packets.
    bus.req = 5'b00001;
    tick(); chk_state("b2b_first", 5'b00001, 1'b1, 3'd1);
    bus.tail_sent = 5'b00001;
    tick(); chk_state("b2b_bubble", 5'b00000, 1'b0, 3'd1);
    bus.tail_sent = '0;
    tick(); chk_state("b2b_second", 5'b00001, 1'b1, 3'd1);
    bus.tail_sent = 5'b00001; bus.req = 5'b00000;
    tick(); chk_state("b2b_done", 5'b00000, 1'b0, 3'd1);
    bus.tail_sent = '0;

    // out_ready gates new allocation.
    bus.req = 5'b00010; bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); chk_state("gated", 5'b00000, 1'b0, 3'd1);
    end
    bus.out_ready = 1'b1;
    tick(); chk_state("ungated", 5'b00010, 1'b1, 3'd2);
    bus.tail_sent = 5'b00010; bus.req = 5'b00000;
    tick(); chk_state("ungated_done", 5'b00000, 1'b0, 3'd2);
    bus.tail_sent = '0;

    // Drop error: granted requester falls without a tail.
    bus.req = 5'b01000;
    tick(); chk_state("drop_grant", 5'b01000, 1'b1, 3'd4);
    bus.req = 5'b00000;
    tick(); chk_state("drop", 5'b00000, 1'b0, 3'd4);
    chk("drop.err_drop", 8'(bus.err_drop), 8'd1);
    tick(); chk("drop.pulse_end", 8'(bus.err_drop), 8'd0);

    // Watchdog: grant held MAX_HOLD cycles, then forced release.
    bus.req = 5'b10000;
    tick(); chk_state("wd_grant", 5'b10000, 1'b1, 3'd0);
    for (int i = 0; i < 3; i++) begin
      tick(); chk_state("wd_hold", 5'b10000, 1'b1, 3'd0);
      chk("wd_hold.err_timeout", 8'(bus.err_timeout), 8'd0);
    end
    tick(); chk_state("wd_fire", 5'b00000, 1'b0, 3'd0);
    chk("wd_fire.err_timeout", 8'(bus.err_timeout), 8'd1);
    chk("wd_fire.err_drop", 8'(bus.err_drop), 8'd0);
    tick(); chk("wd.pulse_end", 8'(bus.err_timeout), 8'd0);
    chk_state("wd_regrant", 5'b10000, 1'b1, 3'd0);

    // Reset mid-packet abandons the stream; allocation resumes afterwards.
    rst = 1'b1;
    tick(); chk_state("rst_mid", 5'b00000, 1'b0, 3'd0);
    rst = 1'b0;
    tick(); chk_state("post_rst", 5'b10000, 1'b1, 3'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
